rr_arbiter_8: RTL and testbench

//  Round-robin arbiter sharing one resource between 8 requesters.

---
 rtl/rr_arbiter_8_pkg.sv | 31 +++
 rtl/rr_arbiter_8_if.sv | 27 ++
 rtl/rr_arbiter_8_decoder.sv | 14 +
 rtl/rr_arbiter_8.sv | 126 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, state encoding and search helper for the 8-way round-robin arbiter.
// ARB_TIMEOUT_EN (optional) bounds each grant to MAX_HOLD cycles.
package rr_arbiter_8_pkg;

    localparam int NREQ     = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Offset of the first set bit in a vector already rotated so bit 0 is the
    // highest-priority requester; returns 0 for an empty vector.
    function automatic logic [IDX_W-1:0] first_set_offset(input logic [NREQ-1:0] vec);
        logic [IDX_W-1:0] off;
        logic             found;
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && vec[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return off;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import rr_arbiter_8_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             gnt_tmo;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  gnt_tmo
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output gnt_tmo
    );

endinterface

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decode of the next winner index; purely combinational.
module arb_idx_decoder
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [NREQ-1:0]  onehot_o
);

    always_comb begin
        onehot_o = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin 8-way arbiter, grant held until release, one idle cycle between grants.
// Latency: req sampled at edge N drives gnt after edge N. ARB_TIMEOUT_EN adds forced release.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_8_if.slave   arb
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             gnt_vld_q, gnt_vld_d;

    logic [NREQ-1:0]  req_rot;
    logic [IDX_W-1:0] winner;
    logic [NREQ-1:0]  idx_onehot;
    logic             release_grant;
    logic             forced;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             gnt_tmo_q, gnt_tmo_d;
`endif

    // Rotate requests so the pointer position is searched first.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rot[i] = arb.req[ptr_q + IDX_W'(i)];
        end
    end

    assign winner = ptr_q + first_set_offset(req_rot);

    arb_idx_decoder u_dec (
        .idx_i    (gnt_idx_d),
        .onehot_o (idx_onehot)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_idx_d     = gnt_idx_q;
        gnt_vld_d     = gnt_vld_q;
        release_grant = 1'b0;
        forced        = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        gnt_tmo_d     = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                gnt_vld_d = 1'b0;
                if (|arb.req) begin
                    state_d   = ARB_GRANT;
                    gnt_idx_d = winner;
                    gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            ARB_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                forced     = arb.req[gnt_idx_q] && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
                gnt_tmo_d  = forced;
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
                release_grant = !arb.req[gnt_idx_q] || forced;
                if (release_grant) begin
                    state_d   = ARB_IDLE;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                gnt_vld_d = 1'b0;
            end
        endcase
        gnt_d = gnt_vld_d ? idx_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            gnt_tmo_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            gnt_tmo_q  <= gnt_tmo_d;
        end
    end

    assign arb.gnt_tmo = gnt_tmo_q;
`else
    assign arb.gnt_tmo = 1'b0;
`endif

    assign arb.gnt     = gnt_q;
    assign arb.gnt_idx = gnt_idx_q;
    assign arb.gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboarded bench for rr_arbiter_8; timeout scenario active when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_8;

    logic clk;
    logic rst_n;

    rr_arbiter_8_if arb_bus();

    rr_arbiter_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic       m_busy;
    logic [2:0] m_ptr;
    logic [2:0] m_idx;
    logic       m_tmo;
    int         m_hold;

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 3'd0;
        m_idx  = 3'd0;
        m_tmo  = 1'b0;
        m_hold = 0;
        sb_q.delete();
    endtask

    task automatic model_edge(input logic [7:0] r);
        exp_t e;
        logic frc;
        frc = 1'b0;
        if (!m_busy) begin
            m_tmo = 1'b0;
            if (r != 8'h00) begin
                for (int i = 7; i >= 0; i--) begin
                    if (r[(int'(m_ptr) + i) % 8]) m_idx = 3'((int'(m_ptr) + i) % 8);
                end
                m_busy = 1'b1;
                m_hold = 0;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            frc = r[m_idx] && (m_hold == 15);
`endif
            if (!r[m_idx] || frc) begin
                m_busy = 1'b0;
                m_ptr  = m_idx + 3'd1;
                m_tmo  = frc;
            end else begin
                m_tmo  = 1'b0;
                m_hold = m_hold + 1;
            end
        end
        e.gnt = m_busy ? (8'h01 << m_idx) : 8'h00;
        e.idx = m_idx;
        e.vld = m_busy;
        e.tmo = m_tmo;
        sb_q.push_back(e);
    endtask

    // Drive req away from the edge, let the DUT and model advance, then compare.
    task automatic step(input logic [7:0] r);
        exp_t e;
        @(negedge clk);
        arb_bus.req = r;
        model_edge(r);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (arb_bus.gnt !== e.gnt || arb_bus.gnt_idx !== e.idx ||
            arb_bus.gnt_vld !== e.vld || arb_bus.gnt_tmo !== e.tmo) begin
            $display("FAIL scoreboard t=%0t req=%b got gnt=%b idx=%0d vld=%b tmo=%b want gnt=%b idx=%0d vld=%b tmo=%b",
                     $time, r, arb_bus.gnt, arb_bus.gnt_idx, arb_bus.gnt_vld, arb_bus.gnt_tmo,
                     e.gnt, e.idx, e.vld, e.tmo);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        arb_bus.req = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (arb_bus.gnt !== 8'h00 || arb_bus.gnt_idx !== 3'd0 ||
            arb_bus.gnt_vld !== 1'b0 || arb_bus.gnt_tmo !== 1'b0) begin
            $display("FAIL reset_state got gnt=%b idx=%0d vld=%b tmo=%b want all zero",
                     arb_bus.gnt, arb_bus.gnt_idx, arb_bus.gnt_vld, arb_bus.gnt_tmo);
        end else n_pass++;
        step(8'h20);
        step(8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (arb_bus.gnt !== 8'h00 || arb_bus.gnt_idx !== 3'd0 || arb_bus.gnt_vld !== 1'b0) begin
            $display("FAIL async_reset_mid_grant got gnt=%b idx=%0d vld=%b want gnt=0 idx=0 vld=0",
                     arb_bus.gnt, arb_bus.gnt_idx, arb_bus.gnt_vld);
        end else n_pass++;
        arb_bus.req = 8'h00;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        step(8'h08);
        n_checks++;
        if (arb_bus.gnt !== 8'h08 || arb_bus.gnt_idx !== 3'd3) begin
            $display("FAIL single_grant got gnt=%b idx=%0d want gnt=00001000 idx=3", arb_bus.gnt, arb_bus.gnt_idx);
        end else n_pass++;
        step(8'h00);
        n_checks++;
        if (arb_bus.gnt !== 8'h00 || arb_bus.gnt_vld !== 1'b0 || arb_bus.gnt_idx !== 3'd3) begin
            $display("FAIL single_release got gnt=%b vld=%b idx=%0d want gnt=0 vld=0 idx=3",
                     arb_bus.gnt, arb_bus.gnt_vld, arb_bus.gnt_idx);
        end else n_pass++;
        // Pointer now at 4: requesters 2 and 4 both asking must pick 4.
        step(8'h14);
        n_checks++;
        if (arb_bus.gnt_idx !== 3'd4) begin
            $display("FAIL ptr_after_release got idx=%0d want 4", arb_bus.gnt_idx);
        end else n_pass++;
        step(8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] req_tab [12] = '{8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h01,
                                     8'h81, 8'h81, 8'h80, 8'h81, 8'h81, 8'h01};
        logic       vld_tab [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        logic [2:0] idx_tab [12] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7,
                                     3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(req_tab[i]);
            n_checks++;
            if (arb_bus.gnt_vld !== vld_tab[i] || arb_bus.gnt_idx !== idx_tab[i]) begin
                $display("FAIL back_to_back[%0d] got vld=%b idx=%0d want vld=%b idx=%0d",
                         i, arb_bus.gnt_vld, arb_bus.gnt_idx, vld_tab[i], idx_tab[i]);
            end else n_pass++;
        end
        step(8'h00);
    endtask

    task automatic test_wrap();
        do_reset();
        step(8'h40);
        step(8'h00);
        step(8'h41);
        n_checks++;
        if (arb_bus.gnt !== 8'h01 || arb_bus.gnt_idx !== 3'd0) begin
            $display("FAIL wrap_first got gnt=%b idx=%0d want gnt=00000001 idx=0", arb_bus.gnt, arb_bus.gnt_idx);
        end else n_pass++;
        step(8'h40);
        step(8'h40);
        n_checks++;
        if (arb_bus.gnt !== 8'h40 || arb_bus.gnt_idx !== 3'd6) begin
            $display("FAIL wrap_second got gnt=%b idx=%0d want gnt=01000000 idx=6", arb_bus.gnt, arb_bus.gnt_idx);
        end else n_pass++;
        step(8'h00);
    endtask

    task automatic test_timeout();
        int   hold;
        int   bad;
        logic done;
        logic tmo_at_rel;
        do_reset();
        step(8'h14);
        hold       = 0;
        bad        = 0;
        done       = 1'b0;
        tmo_at_rel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                if (arb_bus.gnt === 8'h04) hold++;
                else begin
                    done       = 1'b1;
                    tmo_at_rel = arb_bus.gnt_tmo;
                end
            end
            if (arb_bus.gnt_tmo !== 1'b0 && !done) bad++;
            if (!done) step(8'h14);
        end
`ifdef ARB_TIMEOUT_EN
        n_checks++;
        if (hold !== 16 || tmo_at_rel !== 1'b1 || bad != 0) begin
            $display("FAIL timeout_hold got cycles=%0d tmo=%b early_tmo=%0d want cycles=16 tmo=1 early_tmo=0",
                     hold, tmo_at_rel, bad);
        end else n_pass++;
        step(8'h14);
        n_checks++;
        if (arb_bus.gnt !== 8'h10 || arb_bus.gnt_tmo !== 1'b0) begin
            $display("FAIL timeout_next got gnt=%b tmo=%b want gnt=00010000 tmo=0", arb_bus.gnt, arb_bus.gnt_tmo);
        end else n_pass++;
`else
        n_checks++;
        if (done !== 1'b0 || hold !== 40 || bad != 0) begin
            $display("FAIL unbounded_hold got released=%b cycles=%0d tmo_pulses=%0d want released=0 cycles=40 tmo_pulses=0",
                     done, hold, bad);
        end else n_pass++;
`endif
        step(8'h00);
        step(8'h00);
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic [7:0] prev_r;
        logic       prev_vld;
        int         waits [8];
        int         worst;
        int         inv_bad;
        do_reset();
        r        = 8'h00;
        prev_vld = 1'b0;
        inv_bad  = 0;
        for (int k = 0; k < 8; k++) waits[k] = 0;
        for (int c = 0; c < 10000; c++) begin
            prev_r = r;
            if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
            else r = prev_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step(r);
            if (!$onehot0(arb_bus.gnt) || (arb_bus.gnt_vld !== (|arb_bus.gnt)) ||
                (arb_bus.gnt_vld && arb_bus.gnt !== (8'h01 << arb_bus.gnt_idx))) begin
                inv_bad++;
            end
            for (int k = 0; k < 8; k++) if (!r[k]) waits[k] = 0;
            if (arb_bus.gnt_vld && !prev_vld) begin
                worst = 0;
                for (int k = 0; k < 8; k++) begin
                    if (k == int'(arb_bus.gnt_idx)) waits[k] = 0;
                    else if (r[k]) waits[k]++;
                    if (waits[k] > worst) worst = waits[k];
                end
                n_checks++;
                if (worst > 7) begin
                    $display("FAIL starvation t=%0t got wait=%0d grants want at most 7", $time, worst);
                end else n_pass++;
            end
            prev_vld = arb_bus.gnt_vld;
        end
        n_checks++;
        if (inv_bad != 0) begin
            $display("FAIL invariants got violations=%0d want 0", inv_bad);
        end else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        arb_bus.req = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
